// File: rtl/regfile_mp_sb_if.sv
// regfile_mp_sb_if: read, write and scoreboard-allocate bus of the multi-port register file.
interface regfile_mp_sb_if #(
    parameter int DATA_WIDTH  = 32,
    parameter int REG_NUM     = 32,
    parameter int REG_NUM_BIT = 5,
    parameter int NUM_RD      = 3,
    parameter int NUM_WR      = 2
);
    logic [NUM_RD*REG_NUM_BIT-1:0] raddr;
    logic [NUM_RD*DATA_WIDTH-1:0]  rdata;
    logic [NUM_RD-1:0]             rbusy;
    logic [NUM_WR-1:0]             wen;
    logic [NUM_WR*REG_NUM_BIT-1:0] waddr;
    logic [NUM_WR*DATA_WIDTH-1:0]  wdata;
    logic                          alloc_en;
    logic [REG_NUM_BIT-1:0]        alloc_addr;
    logic                          alloc_ok;
    logic [REG_NUM-1:0]            busy_vec;
    modport master (
        output raddr, wen, waddr, wdata, alloc_en, alloc_addr,
        input  rdata, rbusy, alloc_ok, busy_vec
    );
    modport slave (
        input  raddr, wen, waddr, wdata, alloc_en, alloc_addr,
        output rdata, rbusy, alloc_ok, busy_vec
    );
endinterface

// File: rtl/regfile_mp_sb.sv
// regfile_mp_sb: N-read/M-write register file with write bypass, hardwired x0 and a busy scoreboard.
module regfile_mp_sb #(
    parameter int DATA_WIDTH  = 32,
    parameter int REG_NUM     = 32,
    parameter int REG_NUM_BIT = 5,
    parameter int NUM_RD      = 3,
    parameter int NUM_WR      = 2
) (
    input logic            clk,
    input logic            rst_n,
    regfile_mp_sb_if.slave bus
);
    logic [DATA_WIDTH-1:0]        rf [REG_NUM];
    logic [REG_NUM-1:0]           busy;
    logic [NUM_RD*DATA_WIDTH-1:0] rdata_c;
    logic [NUM_RD-1:0]            rbusy_c;
    logic                         alloc_hit;
    logic                         alloc_ok;
    // A same-cycle write to the allocation target counts as its release.
    always_comb begin
        alloc_hit = 1'b0;
        for (int j = 0; j < NUM_WR; j++)
            if (bus.wen[j] && bus.waddr[j*REG_NUM_BIT +: REG_NUM_BIT] == bus.alloc_addr) alloc_hit = 1'b1;
    end
    assign alloc_ok = rst_n && bus.alloc_en &&
                      (bus.alloc_addr == '0 || !busy[bus.alloc_addr] || alloc_hit);
    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [REG_NUM_BIT-1:0] ra;
        logic                   hit;
        logic [DATA_WIDTH-1:0]  byp;
        assign ra = bus.raddr[i*REG_NUM_BIT +: REG_NUM_BIT];
        // Later ports override earlier ones so the highest index wins.
        always_comb begin
            hit = 1'b0;
            byp = '0;
            for (int j = 0; j < NUM_WR; j++)
                if (bus.wen[j] && bus.waddr[j*REG_NUM_BIT +: REG_NUM_BIT] == ra) begin
                    hit = 1'b1;
                    byp = bus.wdata[j*DATA_WIDTH +: DATA_WIDTH];
                end
        end
        assign rdata_c[i*DATA_WIDTH +: DATA_WIDTH] = ra == '0 ? '0 : hit ? byp : rf[ra];
        assign rbusy_c[i] = ra != '0 && !hit && busy[ra];
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < REG_NUM; k++) rf[k] <= '0;
            busy <= '0;
        end else begin
            for (int j = 0; j < NUM_WR; j++)
                if (bus.wen[j] && bus.waddr[j*REG_NUM_BIT +: REG_NUM_BIT] != '0) begin
                    rf[bus.waddr[j*REG_NUM_BIT +: REG_NUM_BIT]]   <= bus.wdata[j*DATA_WIDTH +: DATA_WIDTH];
                    busy[bus.waddr[j*REG_NUM_BIT +: REG_NUM_BIT]] <= 1'b0;
                end
            // Allocation is applied after releases so it wins on the same register.
            if (alloc_ok && bus.alloc_addr != '0) busy[bus.alloc_addr] <= 1'b1;
        end
    end
    assign bus.rdata    = rdata_c;
    assign bus.rbusy    = rbusy_c;
    assign bus.alloc_ok = alloc_ok;
    assign bus.busy_vec = busy;
endmodule

// File: tb/tb_regfile_mp_sb.sv
// tb_regfile_mp_sb: scoreboard-driven checks of reads, bypass, write priority and busy tracking.
module tb_regfile_mp_sb;
    localparam int DW = 32, RN = 32, RB = 5, NR = 3, NW = 2;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int tests = 0;
    int fails = 0;
    logic [DW:0] sb [$];
    logic [DW:0] exp_v;
    logic [DW:0] got_v;
    always #5 clk = ~clk;
    regfile_mp_sb_if #(.DATA_WIDTH(DW), .REG_NUM(RN), .REG_NUM_BIT(RB), .NUM_RD(NR), .NUM_WR(NW)) bus ();
    regfile_mp_sb #(.DATA_WIDTH(DW), .REG_NUM(RN), .REG_NUM_BIT(RB), .NUM_RD(NR), .NUM_WR(NW)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );
    task automatic idle();
        bus.wen = '0;
        bus.waddr = '0;
        bus.wdata = '0;
        bus.alloc_en = 1'b0;
        bus.alloc_addr = '0;
    endtask
    task automatic rd(input logic [RB-1:0] a0, input logic [RB-1:0] a1, input logic [RB-1:0] a2);
        bus.raddr = {a2, a1, a0};
    endtask
    task automatic wr(input int j, input logic [RB-1:0] a, input logic [DW-1:0] d);
        bus.wen[j] = 1'b1;
        bus.waddr[j*RB +: RB] = a;
        bus.wdata[j*DW +: DW] = d;
    endtask
    task automatic push(input logic b, input logic [DW-1:0] d);
        sb.push_back({b, d});
    endtask
    task automatic test_reset();
        idle();
        rd(0, 0, 0);
        bus.alloc_en = 1'b1;
        bus.alloc_addr = 5'd3;
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if (bus.alloc_ok !== 1'b0) begin
            fails++;
            $display("FAIL reset_alloc_ok got=%b expected=0", bus.alloc_ok);
        end
        @(negedge clk);
        rst_n = 1'b1;
        idle();
        #1;
        tests++;
        if (bus.busy_vec !== '0) begin
            fails++;
            $display("FAIL reset_busy_vec got=%h expected=0", bus.busy_vec);
        end
        for (int a = 1; a < RN; a++) begin
            @(negedge clk);
            rd(a[RB-1:0], a[RB-1:0], a[RB-1:0]);
            repeat (NR) push(1'b0, '0);
            #1;
            for (int i = 0; i < NR; i++) begin
                exp_v = sb.pop_front();
                got_v = {bus.rbusy[i], bus.rdata[i*DW +: DW]};
                tests++;
                if (got_v !== exp_v) begin
                    fails++;
                    $display("FAIL reset_read x%0d port%0d got=%h expected=%h", a, i, got_v, exp_v);
                end
            end
        end
    endtask
    task automatic test_write_bypass();
        @(negedge clk);
        idle();
        wr(0, 5, 32'hDEADBEEF);
        wr(1, 6, 32'h12345678);
        rd(5, 6, 0);
        push(1'b0, 32'hDEADBEEF); push(1'b0, 32'h12345678); push(1'b0, 32'h0);
        #1;
        for (int i = 0; i < NR; i++) begin
            exp_v = sb.pop_front();
            got_v = {bus.rbusy[i], bus.rdata[i*DW +: DW]};
            tests++;
            if (got_v !== exp_v) begin
                fails++;
                $display("FAIL bypass port%0d got=%h expected=%h", i, got_v, exp_v);
            end
        end
        @(negedge clk);
        idle();
        push(1'b0, 32'hDEADBEEF); push(1'b0, 32'h12345678); push(1'b0, 32'h0);
        #1;
        for (int i = 0; i < NR; i++) begin
            exp_v = sb.pop_front();
            got_v = {bus.rbusy[i], bus.rdata[i*DW +: DW]};
            tests++;
            if (got_v !== exp_v) begin
                fails++;
                $display("FAIL stored port%0d got=%h expected=%h", i, got_v, exp_v);
            end
        end
    endtask
    task automatic test_write_priority();
        @(negedge clk);
        idle();
        wr(0, 7, 32'h1);
        wr(1, 7, 32'h2);
        rd(7, 7, 7);
        repeat (NR) push(1'b0, 32'h2);
        #1;
        for (int i = 0; i < NR; i++) begin
            exp_v = sb.pop_front();
            got_v = {bus.rbusy[i], bus.rdata[i*DW +: DW]};
            tests++;
            if (got_v !== exp_v) begin
                fails++;
                $display("FAIL same_addr_bypass port%0d got=%h expected=%h", i, got_v, exp_v);
            end
        end
        @(negedge clk);
        idle();
        wr(0, 0, 32'hFFFFFFFF);
        rd(7, 0, 7);
        push(1'b0, 32'h2); push(1'b0, 32'h0); push(1'b0, 32'h2);
        #1;
        for (int i = 0; i < NR; i++) begin
            exp_v = sb.pop_front();
            got_v = {bus.rbusy[i], bus.rdata[i*DW +: DW]};
            tests++;
            if (got_v !== exp_v) begin
                fails++;
                $display("FAIL same_addr_store_x0_write port%0d got=%h expected=%h", i, got_v, exp_v);
            end
        end
        @(negedge clk);
        idle();
        rd(0, 7, 0);
        push(1'b0, 32'h0); push(1'b0, 32'h2); push(1'b0, 32'h0);
        #1;
        for (int i = 0; i < NR; i++) begin
            exp_v = sb.pop_front();
            got_v = {bus.rbusy[i], bus.rdata[i*DW +: DW]};
            tests++;
            if (got_v !== exp_v) begin
                fails++;
                $display("FAIL x0_stored port%0d got=%h expected=%h", i, got_v, exp_v);
            end
        end
    endtask
    task automatic test_scoreboard();
        @(negedge clk);
        idle();
        bus.alloc_en = 1'b1;
        bus.alloc_addr = 5'd10;
        #1;
        tests++;
        if (bus.alloc_ok !== 1'b1) begin
            fails++;
            $display("FAIL alloc_x10 got=%b expected=1", bus.alloc_ok);
        end
        @(negedge clk);
        rd(10, 10, 10);
        repeat (NR) push(1'b1, 32'h0);
        #1;
        tests++;
        if (bus.alloc_ok !== 1'b0) begin
            fails++;
            $display("FAIL alloc_waw_stall got=%b expected=0", bus.alloc_ok);
        end
        for (int i = 0; i < NR; i++) begin
            exp_v = sb.pop_front();
            got_v = {bus.rbusy[i], bus.rdata[i*DW +: DW]};
            tests++;
            if (got_v !== exp_v) begin
                fails++;
                $display("FAIL busy_read port%0d got=%h expected=%h", i, got_v, exp_v);
            end
        end
        @(negedge clk);
        idle();
        wr(0, 10, 32'h55);
        repeat (NR) push(1'b0, 32'h55);
        #1;
        for (int i = 0; i < NR; i++) begin
            exp_v = sb.pop_front();
            got_v = {bus.rbusy[i], bus.rdata[i*DW +: DW]};
            tests++;
            if (got_v !== exp_v) begin
                fails++;
                $display("FAIL release_bypass port%0d got=%h expected=%h", i, got_v, exp_v);
            end
        end
        @(negedge clk);
        idle();
        repeat (NR) push(1'b0, 32'h55);
        #1;
        tests++;
        if (bus.busy_vec !== '0) begin
            fails++;
            $display("FAIL release_busy_vec got=%h expected=0", bus.busy_vec);
        end
        for (int i = 0; i < NR; i++) begin
            exp_v = sb.pop_front();
            got_v = {bus.rbusy[i], bus.rdata[i*DW +: DW]};
            tests++;
            if (got_v !== exp_v) begin
                fails++;
                $display("FAIL release_stored port%0d got=%h expected=%h", i, got_v, exp_v);
            end
        end
    endtask
    task automatic test_back_to_back();
        @(negedge clk);
        idle();
        bus.alloc_en = 1'b1;
        bus.alloc_addr = 5'd12;
        @(negedge clk);
        idle();
        wr(1, 12, 32'hA5);
        bus.alloc_en = 1'b1;
        bus.alloc_addr = 5'd12;
        rd(12, 12, 12);
        repeat (NR) push(1'b0, 32'hA5);
        #1;
        tests++;
        if (bus.alloc_ok !== 1'b1) begin
            fails++;
            $display("FAIL realloc_ok got=%b expected=1", bus.alloc_ok);
        end
        for (int i = 0; i < NR; i++) begin
            exp_v = sb.pop_front();
            got_v = {bus.rbusy[i], bus.rdata[i*DW +: DW]};
            tests++;
            if (got_v !== exp_v) begin
                fails++;
                $display("FAIL realloc_bypass port%0d got=%h expected=%h", i, got_v, exp_v);
            end
        end
        @(negedge clk);
        idle();
        bus.alloc_en = 1'b1;
        bus.alloc_addr = 5'd0;
        repeat (NR) push(1'b1, 32'hA5);
        #1;
        tests++;
        if (bus.alloc_ok !== 1'b1 || bus.busy_vec !== 32'h0000_1000) begin
            fails++;
            $display("FAIL realloc_state alloc_ok=%b busy_vec=%h expected 1 and 00001000", bus.alloc_ok, bus.busy_vec);
        end
        for (int i = 0; i < NR; i++) begin
            exp_v = sb.pop_front();
            got_v = {bus.rbusy[i], bus.rdata[i*DW +: DW]};
            tests++;
            if (got_v !== exp_v) begin
                fails++;
                $display("FAIL realloc_stored port%0d got=%h expected=%h", i, got_v, exp_v);
            end
        end
        @(negedge clk);
        idle();
        #1;
        tests++;
        if (bus.busy_vec !== 32'h0000_1000) begin
            fails++;
            $display("FAIL alloc_x0_nochange got=%h expected=00001000", bus.busy_vec);
        end
    endtask
    task automatic test_reset_mid();
        logic [RB-1:0] regs [3];
        regs = '{5'd3, 5'd4, 5'd9};
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            idle();
            bus.alloc_en = 1'b1;
            bus.alloc_addr = regs[k];
            #1;
            tests++;
            if (bus.alloc_ok !== 1'b1) begin
                fails++;
                $display("FAIL alloc_x%0d got=%b expected=1", regs[k], bus.alloc_ok);
            end
        end
        @(negedge clk);
        idle();
        #1;
        tests++;
        if (bus.busy_vec !== 32'h0000_1218) begin
            fails++;
            $display("FAIL pre_reset_busy got=%h expected=00001218", bus.busy_vec);
        end
        @(negedge clk);
        rst_n = 1'b0;
        bus.alloc_en = 1'b1;
        bus.alloc_addr = 5'd20;
        wr(0, 5'd20, 32'hCAFE);
        #1;
        tests++;
        if (bus.alloc_ok !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid_alloc_ok got=%b expected=0", bus.alloc_ok);
        end
        @(negedge clk);
        rst_n = 1'b1;
        idle();
        #1;
        tests++;
        if (bus.busy_vec !== '0) begin
            fails++;
            $display("FAIL reset_mid_busy_vec got=%h expected=0", bus.busy_vec);
        end
        for (int a = 1; a < RN; a++) begin
            @(negedge clk);
            rd(a[RB-1:0], a[RB-1:0], a[RB-1:0]);
            repeat (NR) push(1'b0, '0);
            #1;
            for (int i = 0; i < NR; i++) begin
                exp_v = sb.pop_front();
                got_v = {bus.rbusy[i], bus.rdata[i*DW +: DW]};
                tests++;
                if (got_v !== exp_v) begin
                    fails++;
                    $display("FAIL reset_mid_read x%0d port%0d got=%h expected=%h", a, i, got_v, exp_v);
                end
            end
        end
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end
    initial begin
        test_reset();
        test_write_bypass();
        test_write_priority();
        test_scoreboard();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
